// File: rtl/data_sram_bridge_if.sv
// data_sram_bridge_if: sram-like bus with addr_ok/data_ok handshakes.
// The bridge drives requests as master; the memory side answers as slave.
interface data_sram_bridge_if;
   logic        bus_req;
   logic        bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
      input  bus_addr_ok, bus_data_ok, bus_rdata
   );

   modport slave (
      input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
      output bus_addr_ok, bus_data_ok, bus_rdata
   );
endinterface

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns the CPU's hold-until-ok data port into single
// outstanding sram-like bus transactions. Stores are posted into a small
// write buffer and retire in one cycle; loads wait until every earlier store
// has completed on the bus, so no forwarding is needed.
module data_sram_bridge #(
   parameter int WB_DEPTH = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               cpu_en,
   input  logic [3:0]         cpu_wen,
   input  logic [31:0]        cpu_addr,
   input  logic [31:0]        cpu_wdata,
   output logic [31:0]        cpu_rdata,
   output logic               cpu_data_ok,
   data_sram_bridge_if.master bus_if
);

   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(WB_DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_DRAIN = 3'd1,
      RD_REQ   = 3'd2,
      RD_DATA  = 3'd3,
      RESP     = 3'd4
   } cpu_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_REQ  = 2'd1,
      W_WAIT = 2'd2
   } wr_state_e;

   cpu_state_e       cpu_state_q, cpu_state_d;
   wr_state_e        wr_state_q, wr_state_d;
   logic [31:0]      cpu_rdata_q, cpu_rdata_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Write-buffer storage; only pointers and count need a reset.
   logic [31:0]      wb_addr_q [WB_DEPTH];
   logic [3:0]       wb_strb_q [WB_DEPTH];
   logic [31:0]      wb_data_q [WB_DEPTH];

   logic             wb_push;
   logic             wb_pop;
   logic             wb_full;
   logic             wb_empty;

   // Fullness is judged on the count at the start of the cycle, so a pop in
   // the same cycle never makes room for a push.
   assign wb_full  = (count_q == DEPTH_CNT);
   assign wb_empty = (count_q == '0);

   assign cpu_data_ok = (cpu_state_q == RESP);
   assign cpu_rdata   = cpu_rdata_q;

   // CPU-side FSM: accepts stores into the buffer, sequences loads on the bus.
   always_comb begin
      cpu_state_d = cpu_state_q;
      cpu_rdata_d = cpu_rdata_q;
      wb_push     = 1'b0;
      case (cpu_state_q)
         IDLE: begin
            if (cpu_en) begin
               if (cpu_wen != 4'b0000) begin
                  if (!wb_full) begin
                     wb_push     = 1'b1;
                     cpu_state_d = RESP;
                  end
               end else begin
                  cpu_state_d = RD_DRAIN;
               end
            end
         end
         RD_DRAIN: begin
            // Loads are ordered behind every buffered or in-flight store.
            if (wb_empty && (wr_state_q == W_IDLE)) begin
               cpu_state_d = RD_REQ;
            end
         end
         RD_REQ: begin
            if (bus_if.bus_addr_ok) begin
               cpu_state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            if (bus_if.bus_data_ok) begin
               cpu_rdata_d = bus_if.bus_rdata;
               cpu_state_d = RESP;
            end
         end
         RESP: begin
            // cpu_en is ignored here: the request being retired is still
            // held by the CPU and must not be accepted a second time.
            cpu_rdata_d = '0;
            cpu_state_d = IDLE;
         end
         default: begin
            cpu_state_d = IDLE;
         end
      endcase
   end

   // Write-drain FSM: pushes the buffer head onto the bus, pops on data_ok.
   always_comb begin
      wr_state_d = wr_state_q;
      wb_pop     = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (!wb_empty && (cpu_state_q != RD_REQ) && (cpu_state_q != RD_DATA)) begin
               wr_state_d = W_REQ;
            end
         end
         W_REQ: begin
            if (bus_if.bus_addr_ok) begin
               wr_state_d = W_WAIT;
            end
         end
         W_WAIT: begin
            if (bus_if.bus_data_ok) begin
               wb_pop     = 1'b1;
               wr_state_d = W_IDLE;
            end
         end
         default: begin
            wr_state_d = W_IDLE;
         end
      endcase
   end

   // FIFO pointer and occupancy update; pointers wrap at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wb_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (wb_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wb_push, wb_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Bus request mux: the write path and the read path are never active together.
   always_comb begin
      bus_if.bus_req   = 1'b0;
      bus_if.bus_wr    = 1'b0;
      bus_if.bus_wstrb = 4'b0000;
      bus_if.bus_addr  = '0;
      bus_if.bus_wdata = '0;
      if (wr_state_q == W_REQ) begin
         bus_if.bus_req   = 1'b1;
         bus_if.bus_wr    = 1'b1;
         bus_if.bus_wstrb = wb_strb_q[rd_ptr_q];
         bus_if.bus_addr  = wb_addr_q[rd_ptr_q];
         bus_if.bus_wdata = wb_data_q[rd_ptr_q];
      end else if (cpu_state_q == RD_REQ) begin
         bus_if.bus_req  = 1'b1;
         bus_if.bus_addr = cpu_addr;
      end
   end

   // State, pointer and load-data registers; reset abandons any bus transfer.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cpu_state_q <= IDLE;
         wr_state_q  <= W_IDLE;
         cpu_rdata_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         cpu_state_q <= cpu_state_d;
         wr_state_q  <= wr_state_d;
         cpu_rdata_q <= cpu_rdata_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Write-buffer storage, written at the tail on each accepted store.
   always_ff @(posedge clk) begin
      if (wb_push) begin
         wb_addr_q[wr_ptr_q] <= cpu_addr;
         wb_strb_q[wr_ptr_q] <= cpu_wen;
         wb_data_q[wr_ptr_q] <= cpu_wdata;
      end
   end

endmodule
